hazard_controller: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage LEGv8 core. It works next to the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use hazards, handled with a one-cycle stall and a bubble;
- taken branches resolved in ID, handled with an IF/ID flush;
- multi-cycle data-memory waits, handled with a whole-pipe freeze.

It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_controller.sv | 99 +++++++++
 tb/tb_hazard_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // XZR reads as zero, so a load targeting it can never create a dependency.
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_RESET   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                     idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, pipe_hold: 1'b1};
  localparam ctrl_t CTRL_LU      = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam ctrl_t CTRL_FLUSH   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                     idex_bubble: 1'b0, pipe_hold: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on synchronous reset and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, branch flush and memory-wait freeze sequencer for the
// 5-stage LEGv8 pipeline, with saturating stall/flush counters.
module hazard_controller #(
  parameter int CNT_W    = 16,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = hazard_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_addr_A,
  input  logic [REG_W-1:0] id_addr_B,
  input  logic             id_use_A,
  input  logic             id_use_B,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_br_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import hazard_pkg::*;

  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   luHit;
  logic   stateLegal;

  assign luHit = ex_mem_read && (ex_rd != ZERO_ADDR) &&
                 ((id_use_A && (id_addr_A == ex_rd)) ||
                  (id_use_B && (id_addr_B == ex_rd)));

  always_comb begin
    case (state_q)
      RUN, LU_STALL, MEM_WAIT: stateLegal = 1'b1;
      default:                 stateLegal = 1'b0;
    endcase
  end

  // MEM_WAIT without mem_busy re-evaluates hazards exactly like RUN;
  // only LU_STALL masks the load-use compare.
  always_comb begin
    ctrl    = CTRL_DEFAULT;
    state_d = RUN;
    if (!reset_n) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
    end else if (!stateLegal) begin
      ctrl    = CTRL_DEFAULT;
      state_d = RUN;
    end else if (mem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
    end else if (luHit && (state_q != LU_STALL)) begin
      ctrl    = CTRL_LU;
      state_d = LU_STALL;
    end else if (id_br_taken) begin
      ctrl    = CTRL_FLUSH;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign pipe_hold   = ctrl.pipe_hold;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (!ctrl.pc_we),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ctrl.ifid_flush),
    .count   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus random checks of hazard_controller against a rule-level model.
module tb_hazard_controller;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [REG_W-1:0] id_addr_A, id_addr_B, ex_rd;
  logic             id_use_A, id_use_B, ex_mem_read, id_br_taken, mem_busy;
  logic             pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: was the previous cycle a load-use stall, plus the two counts.
  bit mPrevStall;
  int mStall;
  int mFlush;

  hazard_controller #(.CNT_W(CNT_W), .REG_W(REG_W), .ZERO_REG(31)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_addr_A   (id_addr_A),
    .id_addr_B   (id_addr_B),
    .id_use_A    (id_use_A),
    .id_use_B    (id_use_B),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_br_taken (id_br_taken),
    .mem_busy    (mem_busy),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_hold   (pipe_hold),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input bit rst, input int aA, input int aB, input bit uA,
                               input bit uB, input bit exR, input int exRd,
                               input bit br, input bit busy);
    reset_n     = rst;
    id_addr_A   = REG_W'(aA);
    id_addr_B   = REG_W'(aB);
    id_use_A    = uA;
    id_use_B    = uB;
    ex_mem_read = exR;
    ex_rd       = REG_W'(exRd);
    id_br_taken = br;
    mem_busy    = busy;
  endtask

  // Compares outputs to the model for the current inputs, then advances the model.
  task automatic checkOutput(input string tag);
    logic [4:0] expCtrl;
    logic [4:0] obsCtrl;
    bit hit;
    bit nextPrev;
    hit = ex_mem_read && (int'(ex_rd) != 31) &&
          ((id_use_A && id_addr_A == ex_rd) || (id_use_B && id_addr_B == ex_rd));
    nextPrev = 1'b0;
    if (!reset_n)                  expCtrl = 5'b00110;
    else if (mem_busy)             expCtrl = 5'b00001;
    else if (hit && !mPrevStall) begin
      expCtrl  = 5'b00010;
      nextPrev = 1'b1;
    end
    else if (id_br_taken)          expCtrl = 5'b11100;
    else                           expCtrl = 5'b11000;
    obsCtrl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold};

    checks++;
    assert (obsCtrl === expCtrl) else begin
      errors++;
      $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, obsCtrl, expCtrl);
    end
    checks++;
    assert (stall_cnt === CNT_W'(mStall)) else begin
      errors++;
      $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, mStall);
    end
    checks++;
    assert (flush_cnt === CNT_W'(mFlush)) else begin
      errors++;
      $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, mFlush);
    end

    if (!reset_n) begin
      mStall = 0;
      mFlush = 0;
    end else begin
      if (expCtrl[4] == 1'b0) mStall = (mStall < SAT) ? mStall + 1 : SAT;
      if (expCtrl[2] == 1'b1) mFlush = (mFlush < SAT) ? mFlush + 1 : SAT;
    end
    mPrevStall = nextPrev;
  endtask

  task automatic step(input string tag, input bit rst, input int aA, input int aB,
                      input bit uA, input bit uB, input bit exR, input int exRd,
                      input bit br, input bit busy);
    applyStimulus(rst, aA, aB, uA, uB, exR, exRd, br, busy);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCount(input string tag, input logic [CNT_W-1:0] obs, input int exp);
    checks++;
    assert (obs === CNT_W'(exp)) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pickReg();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    mPrevStall = 1'b0;
    mStall     = 0;
    mFlush     = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    step("reset_hold", 0, 1, 2, 1, 1, 1, 1, 1, 1);
    step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    step("lu_hit", 1, 3, 0, 1, 0, 1, 3, 0, 0);
    step("lu_mask", 1, 3, 0, 1, 0, 1, 3, 0, 0);
    checkCount("lu_stall_cnt", stall_cnt, 1);

    step("xzr", 1, 31, 0, 1, 0, 1, 31, 0, 0);
    step("unused_B", 1, 0, 5, 1, 1 - 1, 1, 5, 0, 0);

    step("branch", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCount("branch_flush_cnt", flush_cnt, 1);
    step("lu_vs_br", 1, 3, 0, 1, 0, 1, 3, 1, 0);
    step("br_in_lu_stall", 1, 3, 0, 1, 0, 1, 3, 1, 0);

    // Memory freeze over a pending load-use, from a clean reset.
    step("mw_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("mw_busy", 1, 3, 0, 1, 0, 1, 3, 0, 1);
    step("mw_release", 1, 3, 0, 1, 0, 1, 3, 0, 0);
    checkCount("mw_stall_cnt", stall_cnt, 5);

    // Reset during a freeze aborts it.
    step("mw_busy2", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("mw_abort", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("after_abort", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount("abort_stall_cnt", stall_cnt, 0);

    for (int i = 0; i < 20; i++) step("sat_busy", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCount("sat_stall_cnt", stall_cnt, SAT);
    for (int i = 0; i < 18; i++) step("sat_flush", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkCount("sat_flush_cnt", flush_cnt, SAT);

    step("rand_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 39) != 0), pickReg(), pickReg(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 1) == 1), pickReg(),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
